// File: rtl/sumres_display.sv
// sumres_display: display stage for the restSum 4-bit adder/subtractor.
// Latches the 5-bit result and its mode on a load strobe, converts it to sign
// plus decimal magnitude and scans it onto a 4-digit common-anode 7-segment
// display (active-low anodes and segments).
// Optional build macro: SUMRES_ZERO_BLANK_EN suppresses a leading zero in the
// tens digit.
module sumres_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       ctrl,
    input  logic [4:0] res,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       valid
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    // Internal digit codes: 0..9 are decimal digits, the rest are symbols.
    localparam logic [3:0] DigDash  = 4'd10;
    localparam logic [3:0] DigBlank = 4'd15;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [3:0] AnOff    = 4'b1111;

    // Latched result and mode.
    logic [4:0]      res_q, res_d;
    logic            mode_q, mode_d;
    logic            valid_q, valid_d;

    // Refresh divider and scan position.
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            tick;

    // Registered display outputs.
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    // Decoded value.
    logic [4:0]      value;
    logic            sign;
    logic [1:0]      tens;
    logic [3:0]      units;
    logic [3:0]      digit1;
    logic [3:0]      digit2;
    logic [3:0]      sel_digit;

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = SegBlank;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            DigDash: s = 7'b0111111;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Capture path: a load overwrites the latched result unconditionally.
    always_comb begin
        res_d   = res_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (load) begin
            res_d   = res;
            mode_d  = ctrl;
            valid_d = 1'b1;
        end
    end

    // Sign/magnitude: subtract without carry-out means a negative result in
    // two's complement, so magnitude is 16 - S.
    always_comb begin
        value = res_q;
        sign  = 1'b0;
        if (mode_q) begin
            if (res_q[4]) begin
                value = {1'b0, res_q[3:0]};
            end else begin
                value = 5'd16 - {1'b0, res_q[3:0]};
                sign  = 1'b1;
            end
        end
    end

    // Binary to two decimal digits; value never exceeds 31.
    always_comb begin
        if (value >= 5'd30) begin
            tens  = 2'd3;
            units = 4'(value - 5'd30);
        end else if (value >= 5'd20) begin
            tens  = 2'd2;
            units = 4'(value - 5'd20);
        end else if (value >= 5'd10) begin
            tens  = 2'd1;
            units = 4'(value - 5'd10);
        end else begin
            tens  = 2'd0;
            units = value[3:0];
        end
    end

    // Per-position digit codes.
    always_comb begin
`ifdef SUMRES_ZERO_BLANK_EN
        digit1 = (tens == 2'd0) ? DigBlank : {2'b00, tens};
`else
        digit1 = {2'b00, tens};
`endif
        digit2 = sign ? DigDash : DigBlank;
    end

    // Divider and scan index advance; outputs are loaded for the new index.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
    end

    // Digit selected for the position the scan moves to (pre-edge latched data).
    always_comb begin
        sel_digit = DigBlank;
        case (idx_d)
            2'd0:    sel_digit = units;
            2'd1:    sel_digit = digit1;
            2'd2:    sel_digit = digit2;
            default: sel_digit = DigBlank;
        endcase
    end

    // Output registers change only on tick edges.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_of(sel_digit);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= AnOff;
            seg_q   <= SegBlank;
        end else begin
            res_q   <= res_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_sumres_display.sv
// Directed bench for sumres_display with REFRESH_DIV=4.
module tb_sumres_display;

    localparam int unsigned Div = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

`ifdef SUMRES_ZERO_BLANK_EN
    localparam logic [6:0] STens0 = SB;
`else
    localparam logic [6:0] STens0 = S0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       ctrl = 1'b0;
    logic [4:0] res = 5'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       valid;

    int n_checks = 0;
    int n_pass   = 0;

    sumres_display #(
        .REFRESH_DIV(Div)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .ctrl  (ctrl),
        .res   (res),
        .an    (an),
        .seg   (seg),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait (sampling on negedge) until an changes; n = cycles waited.
    task automatic wait_change(output int n);
        logic [3:0] prev;
        prev = an;
        n = 0;
        while (an === prev && n < 4 * Div) begin
            @(negedge clk);
            n++;
        end
        if (an === prev) check("tick_timeout", {28'd0, an}, ~{28'd0, prev});
    endtask

    // Observe one full scan; check the segment pattern shown at each anode.
    task automatic scan4(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_change(n);
            case (an)
                4'b1110: check({tag, "_d0"}, {25'd0, seg}, {25'd0, s0});
                4'b1101: check({tag, "_d1"}, {25'd0, seg}, {25'd0, s1});
                4'b1011: check({tag, "_d2"}, {25'd0, seg}, {25'd0, s2});
                4'b0111: check({tag, "_d3"}, {25'd0, seg}, {25'd0, s3});
                default: check({tag, "_an"}, {28'd0, an}, 32'hE);
            endcase
        end
    endtask

    // Load a new result, then let a full scan period pass so every digit is fresh.
    task automatic do_load(input logic c, input logic [4:0] r, input string tag);
        @(negedge clk);
        load = 1'b1;
        ctrl = c;
        res  = r;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        repeat (4 * Div + 2) @(negedge clk);
    endtask

    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];

    initial begin
        int n;
        exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_seg = '{STens0, SB, SB, S0};

        // 1: reset state and scan order
        repeat (2) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_an", {28'd0, an}, 32'hF);
        check("pre_tick_seg", {25'd0, seg}, 32'h7F);
        n = 0;
        wait_change(n);
        check("first_tick_lat", n, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_change(n);
                check("period", n, Div);
            end
            check("scan_an", {28'd0, an}, {28'd0, exp_an[i]});
            check("scan_seg", {25'd0, seg}, {25'd0, exp_seg[i]});
        end
        check("idle_valid", {31'd0, valid}, 32'd0);

        // 2: add 27
        do_load(1'b0, 5'b11011, "add27");
        scan4("add27", S7, S2, SB, SB);
        // add 31: tens digit 3
        do_load(1'b0, 5'b11111, "add31");
        scan4("add31", S1, S3, SB, SB);
        // 3: subtract with carry -> +3
        do_load(1'b1, 5'b10011, "sub_p3");
        scan4("sub_p3", S3, STens0, SB, SB);
        // 4: subtract without carry -> -3
        do_load(1'b1, 5'b01101, "sub_m3");
        scan4("sub_m3", S3, STens0, SD, SB);
        // 5: -16 boundary
        do_load(1'b1, 5'b00000, "sub_m16");
        scan4("sub_m16", S6, S1, SD, SB);

        // 6: load coincident with tick into digit 0 shows the old value first
        n = 0;
        for (int i = 0; i < 4 && an !== 4'b0111; i++) wait_change(n);
        check("align_an", {28'd0, an}, 32'h7);
        repeat (Div - 1) @(negedge clk);
        load = 1'b1;
        ctrl = 1'b0;
        res  = 5'd1;
        @(negedge clk);
        load = 1'b0;
        check("coinc_an", {28'd0, an}, 32'hE);
        check("coinc_old_seg", {25'd0, seg}, {25'd0, S6});
        for (int i = 0; i < 4; i++) wait_change(n);
        check("coinc_new_an", {28'd0, an}, 32'hE);
        check("coinc_new_seg", {25'd0, seg}, {25'd0, S1});

        // asynchronous reset mid-period, no clock edge in between
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_an", {28'd0, an}, 32'hF);
        check("async_seg", {25'd0, seg}, 32'h7F);
        check("async_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_change(n);
        check("restart_lat", n, Div);
        check("restart_an", {28'd0, an}, 32'hD);
        check("restart_seg", {25'd0, seg}, {25'd0, STens0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sumres_display.md
Name: sumres_display

Overview:
- Downstream display stage for the 4-bit adder/subtractor `restSum`.
- Captures the adder's 5-bit result (C0,S4..S1) and the operation mode on a load strobe.
- Converts the result to sign + decimal magnitude and drives a 4-digit multiplexed common-anode 7-segment display on the lab board.

Parameters:
- REFRESH_DIV, default 50000: clock cycles per digit slot (refresh tick period); legal range >= 2.

Ports:
- clk    input   1  system clock, rising edge
- rst    input   1  reset, asynchronous, active-high
- load   input   1  capture strobe; res and ctrl are sampled on any rising edge with load=1
- ctrl   input   1  mode of the captured result: 0 = add, 1 = subtract (same meaning as restSum Ctrl)
- res    input   5  restSum result; res[4]=C0, res[3:0]=S4..S1
- an     output  4  digit anodes, active-low, one-hot-low when scanning; an[0] = rightmost digit
- seg    output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- valid  output  1  high once at least one load has been captured since reset

Behaviour:
- Reset is asynchronous and active-high. While asserted and immediately after release:
  - an=4'b1111, seg=7'b1111111, valid=0.
  - Latched result=0, latched mode=0.
  - Divider counter=0, scan index=0.
- Capture: on a rising edge with load=1, the latched result takes res and the latched mode takes ctrl; valid goes to 1 on the same edge. A load while valid=1 overwrites the latched value. There is no back-pressure.
- Value decode (combinational from the latched registers):
  - Mode 0: value = res (0..31), sign=0.
  - Mode 1, C0=1: value = res[3:0], sign=0.
  - Mode 1, C0=0: value = 16 - res[3:0] (1..16, 5-bit), sign=1. res[3:0]=0 gives -16.
  - tens = value/10 (0..3); units = value mod 10.
- Digit map:
  - digit0 = units.
  - digit1 = tens.
  - digit2 = '-' if sign else blank.
  - digit3 = blank.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - '-'=0111111, blank=1111111.
- Refresh:
  - Divider counts 0..REFRESH_DIV-1 and wraps.
  - Tick = the cycle where the count is REFRESH_DIV-1.
  - On each tick edge the scan index advances 0→1→2→3→0, and an/seg are registered for the digit the index moves to.
  - The first tick after reset selects digit 1; digit 0 follows three ticks later.
  - an and seg change only on tick edges, so they stay stable for exactly REFRESH_DIV cycles.
- Simultaneous load and tick: seg for that tick is decoded from the pre-edge latched value. The new value first appears at the next tick.
- Latency from load to visible digit: at most 4*REFRESH_DIV+1 cycles.
- While valid=0, digits are still scanned and display the reset value "0" (digit0 '0', digit1 '0', digits 2-3 blank).
- Reset asserted mid-scan: outputs return to reset values within the same cycle (asynchronous); the scan restarts from index 0 after release.

Optional Feature:
- Macro: SUMRES_ZERO_BLANK_EN.
- Defined: digit1 shows blank when tens=0, i.e. leading-zero suppression.
  - Example: 3 → " 3", -3 → "- 3".
- Undefined: digit1 always shows the tens digit, including '0'.

Test Plan (REFRESH_DIV=4, macro undefined unless stated):
1. Reset pulse, then run 16 cycles → an=1111 and seg=1111111 until the first tick. Per tick, an cycles 1101, 1011, 0111, 1110. On an=1110, seg=1000000; on an=1101, seg=1000000; valid=0.
2. load with ctrl=0, res=5'b11011 (27) → valid=1. On an=1110, seg=1111000 ('7'); on an=1101, seg=0100100 ('2'); on an=1011 and 0111, seg=1111111.
3. load with ctrl=1, res=5'b10011 → on an=1110, seg=0110000 ('3'); on an=1101, seg=1000000 ('0'); on an=1011, blank. Rerun with SUMRES_ZERO_BLANK_EN → an=1101 shows 1111111.
4. load with ctrl=1, res=5'b01101 → displays -3: on an=1011, seg=0111111; on an=1110, seg=0110000.
5. load with ctrl=1, res=5'b00000 → displays -16: on an=1101, seg=1111001; on an=1110, seg=0000010; on an=1011, seg=0111111.
6. load asserted in the same cycle as a tick, then rst asserted mid-period → the tick shows the old value. rst forces an=1111, seg=1111111, valid=0 in the same cycle, with no clock edge required.
